id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
ID/EX pipeline register sitting directly downstream of the decode control unit in the 5-stage MIPS pipeline. Captures the WB/M/EX control bundles and the decoded operands each cycle, then presents them to EX. Contains load-use hazard detection: it injects a bubble and asserts a stall back to PC and IF/ID. Supports external freeze and branch/jump flush, and counts inserted load-use bubbles.

Parameters:
DATA_W, 32, datapath width of register operands, immediate and PC+4
REG_AW, 5, register-file address width
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  input  1  pipeline clock
rst_n  input  1  synchronous active-low reset
stall_i  input  1  global freeze (e.g. memory wait); hold all state
flush_i  input  1  squash the ID instruction (taken branch/jump)
id_wb  input  2  {RegWrite, MemtoReg} from control
id_m  input  3  {Branch, MemRead, MemWrite} from control
id_ex  input  6  {RegDst, ALUSrc, ALUControl[3:0]} from control
id_rs_data  input  DATA_W  register file read port A
id_rt_data  input  DATA_W  register file read port B
id_imm  input  DATA_W  sign-extended immediate
id_pc4  input  DATA_W  PC+4 of the ID instruction (JAL/JALR link)
id_rs  input  REG_AW  rs field
id_rt  input  REG_AW  rt field
id_rd  input  REG_AW  rd field
id_shamt  input  5  shamt field
ex_wb  output  2  registered WB bundle
ex_m  output  3  registered M bundle
ex_ex  output  6  registered EX bundle
ex_rs_data, ex_rt_data, ex_imm, ex_pc4  output  DATA_W  registered operands
ex_rs, ex_rt, ex_rd  output  REG_AW  registered register fields (for forwarding and RegDst)
ex_shamt  output  5  registered shamt
ex_valid  output  1  1 = real instruction in EX, 0 = bubble
hazard_stall_o  output  1  combinational; hold PC and IF/ID this cycle
bubble_count_o  output  CNT_W  saturating count of load-use bubbles inserted

Behaviour:
- Reset (rst_n=0 at the clk edge): every registered output is 0, including ex_valid and bubble_count_o. Reset overrides all other inputs.
- Load-use hazard, combinational: lu = ex_valid & ex_m[1] & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)). Both source fields are compared for every opcode; the resulting conservative stalls are accepted.
- hazard_stall_o = lu & ~flush_i. A squashed instruction is never stalled.
- Per rising edge, in priority order:
  1. stall_i=1: hold all registers; counter unchanged.
  2. flush_i=1: insert a bubble.
  3. lu=1: insert a bubble and increment the counter.
  4. Otherwise: load all id_* inputs and set ex_valid=1.
- Bubble: ex_wb=0, ex_m=0, ex_ex=0, ex_valid=0. Data and field registers are don't-care and may load or hold; the bench must not check them.
- A bubble is never passed through from control: the control default has RegWrite=1, so the zeroing is explicit.
- Latency: 1 cycle from ID to EX outputs. hazard_stall_o is asserted for exactly 1 cycle per load-use pair (no forwarding from the load's MEM stage).
- Counter: +1 per lu bubble; saturates at all-ones with no wrap. Flush bubbles are not counted.
- When stall_i is high, lu may still evaluate high and drive hazard_stall_o. This is harmless because the whole pipeline is frozen.

Decomposition:
- Shared package mips_pkg holds:
  - widths WB_W=2, M_W=3, EX_W=6
  - bit indices REG_WRITE_BIT=1, MEMTOREG_BIT=0, BRANCH_BIT=2, MEM_READ_BIT=1, MEM_WRITE_BIT=0
  - ALU control encodings (AND 0000, OR 0001, ADD 0010, SRL 0011, SUB 0110, SLT 0111, XOR 1001, SLL 1010, SRA 1011, NOR 1100)
- One sub-module: load_use_detect. Purely combinational; computes lu from ex_valid, ex_m, ex_rt, id_rs, id_rt.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random id_* inputs -> all outputs 0; hazard_stall_o=0.
- Pass-through: id_wb=2'b10, id_ex=6'b100010, id_rs_data=0x12345678, then 1 edge -> ex_* equal the inputs, ex_valid=1.
- Load-use: EX holds lw (ex_m=3'b010, ex_rt=8); ID add with id_rs=8 -> hazard_stall_o=1; next edge gives a bubble (ex_wb=0, ex_valid=0) and bubble_count_o=1; following edge loads the add.
- No false hazard: lw with ex_rt=0 and id_rs=0 -> hazard_stall_o=0, no bubble.
- Flush vs load-use: lu condition true and flush_i=1 -> hazard_stall_o=0; bubble inserted; counter unchanged.
- Freeze and saturation: stall_i=1 for 3 cycles -> all outputs constant. With CNT_W=2, 5 consecutive lu bubbles -> bubble_count_o=3.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: control bundle widths, bundle bit positions and ALU control
// encodings shared across the 5-stage MIPS pipeline.
//   WB bundle  = {RegWrite, MemtoReg}
//   M bundle   = {Branch, MemRead, MemWrite}
//   EX bundle  = {RegDst, ALUSrc, ALUControl[3:0]}
package mips_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 6;

    localparam int REG_WRITE_BIT = 1;
    localparam int MEMTOREG_BIT  = 0;
    localparam int BRANCH_BIT    = 2;
    localparam int MEM_READ_BIT  = 1;
    localparam int MEM_WRITE_BIT = 0;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SRL = 4'b0011,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_XOR = 4'b1001,
        ALU_SLL = 4'b1010,
        ALU_SRA = 4'b1011,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard check between the
// instruction in EX and the instruction currently in ID.
//   ex_valid    : EX holds a real instruction
//   ex_mem_read : MemRead bit of the EX M bundle (EX is a load)
//   ex_rt       : destination register of the load
//   id_rs/id_rt : source fields of the ID instruction
//   lu          : 1 = ID needs the load result before it exists
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              lu
);

    // Both source fields are compared regardless of opcode; a load into $0
    // never creates a dependency because $0 is hard-wired.
    assign lu = ex_valid & ex_mem_read & (ex_rt != {REG_AW{1'b0}})
              & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion.
//   clk, rst_n          : clock, synchronous active-low reset
//   stall_i             : global freeze, all state held
//   flush_i             : squash the ID instruction (branch/jump taken)
//   id_wb/id_m/id_ex    : control bundles from decode
//   id_*_data, id_imm, id_pc4, id_rs/rt/rd, id_shamt : decoded operands
//   ex_*                : registered copies presented to EX
//   ex_valid            : 1 = real instruction, 0 = bubble
//   hazard_stall_o      : combinational, hold PC and IF/ID this cycle
//   bubble_count_o      : saturating count of load-use bubbles
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [WB_W-1:0]   id_wb,
    input  logic [M_W-1:0]    id_m,
    input  logic [EX_W-1:0]   id_ex,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [4:0]        id_shamt,
    output logic [WB_W-1:0]   ex_wb,
    output logic [M_W-1:0]    ex_m,
    output logic [EX_W-1:0]   ex_ex,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [4:0]        ex_shamt,
    output logic              ex_valid,
    output logic              hazard_stall_o,
    output logic [CNT_W-1:0]  bubble_count_o
);

    logic lu_s;

    load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_m[MEM_READ_BIT]),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .lu          (lu_s)
    );

    // A squashed instruction will never execute, so it must not hold the front end.
    assign hazard_stall_o = lu_s & ~flush_i;

    // Pipeline register: freeze > flush bubble > load-use bubble > load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_wb          <= {WB_W{1'b0}};
            ex_m           <= {M_W{1'b0}};
            ex_ex          <= {EX_W{1'b0}};
            ex_rs_data     <= {DATA_W{1'b0}};
            ex_rt_data     <= {DATA_W{1'b0}};
            ex_imm         <= {DATA_W{1'b0}};
            ex_pc4         <= {DATA_W{1'b0}};
            ex_rs          <= {REG_AW{1'b0}};
            ex_rt          <= {REG_AW{1'b0}};
            ex_rd          <= {REG_AW{1'b0}};
            ex_shamt       <= 5'd0;
            ex_valid       <= 1'b0;
            bubble_count_o <= {CNT_W{1'b0}};
        end else if (stall_i) begin
            ex_valid <= ex_valid;
        end else if (flush_i || lu_s) begin
            // Control is zeroed explicitly: the decode default has RegWrite=1,
            // so forwarding the ID bundle would not be a harmless no-op.
            // Operand registers simply hold.
            ex_wb    <= {WB_W{1'b0}};
            ex_m     <= {M_W{1'b0}};
            ex_ex    <= {EX_W{1'b0}};
            ex_valid <= 1'b0;
            if (!flush_i && (bubble_count_o != {CNT_W{1'b1}})) begin
                bubble_count_o <= bubble_count_o + CNT_W'(1);
            end
        end else begin
            ex_wb      <= id_wb;
            ex_m       <= id_m;
            ex_ex      <= id_ex;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_pc4     <= id_pc4;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_shamt   <= id_shamt;
            ex_valid   <= 1'b1;
        end
    end

endmodule
